// File: rtl/cp0_timer_irq_unit.sv
`default_nettype none
// ============================================================================
// cp0_timer_irq_unit: CP0 Count/Compare timer, Cause.IP/TI and interrupt request
// Optional macro CP0_TIMER_ZERO_GATE_EN: suppress timer match while compare==0
// Revision: 1.0
// ============================================================================
module cp0_timer_irq_unit #(
  parameter int NUM_HW_IRQ   = 6,
  parameter int COUNT_DIV    = 2,
  parameter int TIMER_IP_BIT = 7,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_IRQ-1:0] hw_irq,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [4:0]            rd_addr,
  output logic [31:0]           rd_data,
  input  logic [7:0]            status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  output logic [31:0]           count,
  output logic [31:0]           compare,
  output logic [7:0]            cause_ip,
  output logic                  cause_ti,
  output logic                  irq_req
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam int PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);

  logic [PRE_W-1:0]      prescaler;
  logic [1:0]            sw_ip;
  logic [NUM_HW_IRQ-1:0] sync_q [SYNC_STAGES];
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_cause;
  logic                  tick;
  logic                  timer_match;
  logic [7:0]            ip_next;

  assign wr_count   = wr_en && (wr_addr == ADDR_COUNT);
  assign wr_compare = wr_en && (wr_addr == ADDR_COMPARE);
  assign wr_cause   = wr_en && (wr_addr == ADDR_CAUSE);
  assign tick       = (prescaler == PRE_MAX);

`ifdef CP0_TIMER_ZERO_GATE_EN
  assign timer_match = (count == compare) && (compare != 32'h0);
`else
  assign timer_match = (count == compare);
`endif

  // Count writes restart the prescale period and take priority over a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= 32'h0;
      compare   <= 32'h0;
      cause_ti  <= 1'b0;
      prescaler <= '0;
      sw_ip     <= 2'b00;
    end else begin
      if (wr_count) begin
        count     <= wr_data;
        prescaler <= '0;
      end else if (tick) begin
        count     <= count + 32'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      if (wr_compare) begin
        compare  <= wr_data;
        cause_ti <= 1'b0;
      end else if (timer_match) begin
        cause_ti <= 1'b1;
      end

      if (wr_cause) begin
        sw_ip <= wr_data[9:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= hw_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_comb begin
    ip_next                  = 8'h00;
    ip_next[1:0]             = sw_ip;
    ip_next[2 +: NUM_HW_IRQ] = sync_q[SYNC_STAGES-1];
    ip_next[TIMER_IP_BIT]    = ip_next[TIMER_IP_BIT] | cause_ti;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_ip <= 8'h00;
      irq_req  <= 1'b0;
    end else begin
      cause_ip <= ip_next;
      irq_req  <= status_ie & ~status_exl & (|(cause_ip & status_im));
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      ADDR_COUNT:   rd_data = count;
      ADDR_COMPARE: rd_data = compare;
      ADDR_CAUSE:   rd_data = {1'b0, cause_ti, 14'b0, cause_ip, 8'b0};
      default:      rd_data = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cp0_timer_irq_unit.md
Name: cp0_timer_irq_unit

Overview:
Parametrised Count/Compare timer and interrupt-pending unit for the CP0 complex. It generalises the fixed 6-line, divide-by-2 scheme: configurable hardware IRQ count, count prescale, timer IP bit and input synchroniser depth. It produces the Cause IP/TI view and a registered, masked interrupt request for the exception logic. It is written from the WB-stage CP0 write port and read by MFC0.

Parameters:
NUM_HW_IRQ, 6, number of external IRQ lines (1..6), mapped to IP[2+i]
COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16)
TIMER_IP_BIT, 7, IP bit (2..7) that the timer interrupt is ORed into
SYNC_STAGES, 2, synchroniser flops per hw_irq line (1..3)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
hw_irq  in  NUM_HW_IRQ  asynchronous level interrupt inputs
wr_en  in  1  CP0 write strobe (WB stage)
wr_addr  in  5  CP0 register number: 9 Count, 11 Compare, 13 Cause
wr_data  in  32  write data
rd_addr  in  5  read register number
rd_data  out  32  combinational read data
status_im  in  8  Status.IM[7:0]
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
count  out  32  Count register
compare  out  32  Compare register
cause_ip  out  8  registered Cause.IP[7:0]
cause_ti  out  1  Cause.TI, sticky timer interrupt flag
irq_req  out  1  registered masked interrupt request

Behaviour:
- Reset (rst=0, asynchronous): count, compare, cause_ip, cause_ti, irq_req, prescaler, software IP[1:0] and all synchroniser flops are 0.
- Prescaler: counts 0..COUNT_DIV-1. Count increments at the edge where prescaler==COUNT_DIV-1, and the prescaler wraps to 0. With COUNT_DIV=1, Count increments every clock.
- Count write (wr_en, addr 9): count<=wr_data and prescaler<=0. The write wins over a same-edge increment.
- Count wraps 0xFFFFFFFF -> 0x00000000 silently. Wrap has no side effect.
- Timer match: at any edge where count==compare (current register values) and there is no Compare write this cycle, cause_ti<=1. cause_ti is sticky.
- Compare write (addr 11): compare<=wr_data and cause_ti<=0. The clear wins over a same-edge match.
- Cause write (addr 13): only IP[1:0]<=wr_data[9:8]. All other bits are ignored.
- Writes to other addresses are ignored.
- Synchroniser: hw_irq[i] passes through SYNC_STAGES flops.
- cause_ip register, loaded every edge:
  - [1:0] = software IP
  - [2+i] = synchronised hw_irq[i]
  - unused lines = 0
  - bit TIMER_IP_BIT is additionally ORed with cause_ti
- irq_req<= status_ie & ~status_exl & |(cause_ip & status_im), registered.
- Latency: hw_irq sampled high at edge k -> cause_ip bit set at edge k+SYNC_STAGES -> irq_req at edge k+SYNC_STAGES+1. Deassertion has the same latency.
- Software IP write at edge k -> cause_ip at k+1 -> irq_req at k+2.
- rd_data decode:
  - 9 -> count
  - 11 -> compare
  - 13 -> {1'b0, cause_ti, 14'b0, cause_ip, 8'b0}
  - any other address -> 32'h0
- Reset mid-operation: immediate clear; no pending request survives reset.

Optional Feature:
Macro CP0_TIMER_ZERO_GATE_EN.
- Defined: timer match is suppressed while compare==0 (legacy compatibility); reset therefore never raises TI.
- Undefined: compare==0 matches like any other value. Count=0 after reset sets cause_ti on the first edge where count==0 and no Compare write occurs.

Test Plan:
1. COUNT_DIV=2: write Count=0x10 at edge 0 -> count reads 0x10 at edges 1-2, 0x11 at edge 3, 0x12 at edge 5.
2. Compare=0x12, IM[7]=1, IE=1, EXL=0, count reaches 0x12 -> cause_ti=1 next edge, cause_ip[7]=1 one edge later, irq_req=1 one edge after that. Write Compare=0x40 -> cause_ti=0 next edge; irq_req drops 2 edges later.
3. hw_irq[0] pulse high, SYNC_STAGES=2, IM[2]=1 -> cause_ip[2] at k+2, irq_req at k+3. With EXL=1 the same stimulus keeps irq_req=0.
4. Write Count=0xFFFFFFFF, COUNT_DIV=1 -> count=0x00000000 next edge, no TI unless compare==0 (macro undefined).
5. Same-edge Compare write while count==compare -> cause_ti stays 0. Same-edge Count write while the prescaler fires -> count equals written value.
6. Cause write 0x00000300 -> rd_data(13)=0x00000300 after one edge. rd_addr=5 -> 0x0. Assert rst mid-count -> all outputs 0 immediately.
